// File: rtl/dle_pkg.sv
// Shared types and arithmetic for the dense layer engine: FSM state encoding
// plus the saturate / requantize helpers used by every MAC lane.
package dle_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPUTE = 3'd2,
    S_FLUSH   = 3'd3,
    S_EMIT    = 3'd4,
    S_DONE    = 3'd5
  } dle_state_e;

  // Working width for requantization; accumulators are sign-extended to this.
  localparam int QW = 64;

  function automatic logic signed [QW-1:0] saturate(
    input logic signed [QW-1:0] x,
    input int unsigned          data_bit
  );
    logic signed [QW-1:0] hi;
    logic signed [QW-1:0] lo;
    hi = (64'sd1 <<< (data_bit - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (x > hi)      saturate = hi;
    else if (x < lo) saturate = lo;
    else             saturate = x;
  endfunction

  function automatic logic signed [QW-1:0] requantize(
    input logic signed [QW-1:0] acc,
    input logic [4:0]           shift,
    input logic                 relu_en,
    input int unsigned          data_bit
  );
    logic signed [QW-1:0] sat;
    sat = saturate(acc >>> shift, data_bit);
    if (relu_en && sat < 0) requantize = '0;
    else                    requantize = sat;
  endfunction

endpackage

// File: rtl/dense_layer_engine_lane.sv
// One MAC lane: signed accumulator with clear-on-first-product, plus the
// requantized result of the current accumulator value.
module dle_lane
  import dle_pkg::*;
#(
  parameter int DATA_BIT = 8,
  parameter int ACC_BIT  = 24
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       en,
  input  logic signed [DATA_BIT-1:0] act,
  input  logic signed [DATA_BIT-1:0] weight,
  input  logic [4:0]                 shift,
  input  logic                       relu_en,
  output logic signed [DATA_BIT-1:0] q
);

  logic signed [2*DATA_BIT-1:0] prod;
  logic signed [ACC_BIT-1:0]    prod_ext;
  logic signed [ACC_BIT-1:0]    acc;
  logic signed [QW-1:0]         rq;

  assign prod     = act * weight;
  assign prod_ext = ACC_BIT'(prod);

  // Wraps modulo 2^ACC_BIT by construction; no overflow tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (en) begin
      acc <= clear ? prod_ext : acc + prod_ext;
    end
  end

  assign rq = requantize(QW'(acc), shift, relu_en, DATA_BIT);
  assign q  = rq[DATA_BIT-1:0];

endmodule

// File: rtl/dense_layer_engine.sv
// Dense layer engine: loads an activation vector, runs LANES neurons per group
// against a 1-cycle-latency weight memory and streams requantized results.
// Optional build macro ARGMAX_EN enables the predict_label argmax tracker.
module dense_layer_engine
  import dle_pkg::*;
#(
  parameter int DATA_BIT = 8,
  parameter int ACC_BIT  = 24,
  parameter int LANES    = 4,
  parameter int IN_LEN   = 64,
  parameter int OUT_NUM  = 10,
  parameter int ADDR_BIT = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [4:0]                shift,
  input  logic                      relu_en,
  input  logic                      act_valid,
  output logic                      act_ready,
  input  logic [DATA_BIT-1:0]       act_data,
  output logic [ADDR_BIT-1:0]       weight_addr,
  input  logic [LANES*DATA_BIT-1:0] weight_rdata,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [DATA_BIT-1:0]       res_data,
  output logic [3:0]                res_idx,
  output logic [3:0]                predict_label,
  output logic                      busy,
  output logic                      done,
  output dle_state_e                dbg_state
);

  localparam int NUM_GROUPS = (OUT_NUM + LANES - 1) / LANES;
  localparam int I_W = (IN_LEN > 1) ? $clog2(IN_LEN) : 1;
  localparam int G_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS + 1) : 1;
  localparam int K_W = (LANES > 1) ? $clog2(LANES) : 1;

  // Handshakes: a beat transfers on a rising edge where valid and ready are
  // both high; a valid source holds its payload until that edge.
  dle_state_e state, state_next;

  logic [I_W-1:0]             i_cnt;
  logic [G_W-1:0]             g_cnt;
  logic [K_W-1:0]             k_cnt;
  logic [4:0]                 shift_q;
  logic                       relu_q;
  logic signed [DATA_BIT-1:0] act_buf [IN_LEN];
  logic signed [DATA_BIT-1:0] act_q;
  logic                       mac_en_d;
  logic                       mac_clr_d;
  logic signed [DATA_BIT-1:0] lane_q [LANES];
  logic [31:0]                cur_idx;
  logic                       i_last;
  logic                       last_neuron;
  logic                       lane_last;

  assign cur_idx     = 32'(g_cnt) * LANES + 32'(k_cnt);
  assign i_last      = (i_cnt == I_W'(IN_LEN - 1));
  assign last_neuron = (cur_idx == 32'(OUT_NUM - 1));
  assign lane_last   = (k_cnt == K_W'(LANES - 1)) || last_neuron;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (start) state_next = S_LOAD;
      S_LOAD:    if (act_valid && i_last) state_next = S_COMPUTE;
      S_COMPUTE: if (i_last) state_next = S_FLUSH;
      S_FLUSH:   state_next = S_EMIT;
      S_EMIT:    if (res_ready && lane_last) state_next = last_neuron ? S_DONE : S_COMPUTE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_cnt   <= '0;
      g_cnt   <= '0;
      k_cnt   <= '0;
      shift_q <= '0;
      relu_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            shift_q <= shift;
            relu_q  <= relu_en;
            i_cnt   <= '0;
            g_cnt   <= '0;
            k_cnt   <= '0;
          end
        end
        S_LOAD: begin
          if (act_valid) i_cnt <= i_last ? '0 : i_cnt + 1'b1;
        end
        S_COMPUTE: begin
          i_cnt <= i_last ? '0 : i_cnt + 1'b1;
        end
        S_EMIT: begin
          if (res_ready) begin
            if (lane_last) begin
              k_cnt <= '0;
              if (!last_neuron) g_cnt <= g_cnt + 1'b1;
            end else begin
              k_cnt <= k_cnt + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_LOAD && act_valid) act_buf[i_cnt] <= $signed(act_data);
  end

  // Activation and control are delayed one cycle to line up with weight_rdata.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_q     <= '0;
      mac_en_d  <= 1'b0;
      mac_clr_d <= 1'b0;
    end else begin
      act_q     <= act_buf[i_cnt];
      mac_en_d  <= (state == S_COMPUTE);
      mac_clr_d <= (state == S_COMPUTE) && (i_cnt == '0);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    dle_lane #(
      .DATA_BIT(DATA_BIT),
      .ACC_BIT (ACC_BIT)
    ) u_lane (
      .clk    (clk),
      .rst    (rst),
      .clear  (mac_clr_d),
      .en     (mac_en_d),
      .act    (act_q),
      .weight (weight_rdata[k*DATA_BIT +: DATA_BIT]),
      .shift  (shift_q),
      .relu_en(relu_q),
      .q      (lane_q[k])
    );
  end

  assign weight_addr = (state == S_COMPUTE) ? ADDR_BIT'(32'(g_cnt) * IN_LEN + 32'(i_cnt)) : '0;
  assign act_ready   = (state == S_LOAD);
  assign res_valid   = (state == S_EMIT);
  assign res_data    = (state == S_EMIT) ? lane_q[k_cnt] : '0;
  assign res_idx     = (state == S_EMIT) ? 4'(cur_idx) : '0;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign dbg_state   = state;

`ifdef ARGMAX_EN
  logic signed [DATA_BIT-1:0] best_val;
  logic [3:0]                 best_idx;

  // Strictly-greater update keeps the lowest index on ties.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      best_val <= '0;
      best_idx <= '0;
    end else if (state == S_IDLE && start) begin
      best_val <= {1'b1, {(DATA_BIT-1){1'b0}}};
      best_idx <= '0;
    end else if (state == S_EMIT && res_ready) begin
      if ($signed(res_data) > best_val) begin
        best_val <= $signed(res_data);
        best_idx <= res_idx;
      end
    end
  end

  assign predict_label = best_idx;
`else
  assign predict_label = 4'd0;
`endif

endmodule
